// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
//   fetch_state_e : fetch FSM states
//   if_id_t       : IF/ID pipeline register payload
//   align_word()  : clears the byte-offset bits of an address
package fetch_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] PC_INC        = 32'd4;
  localparam logic [XLEN-1:0] DEF_RESET_PC  = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEF_NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] npc;
    logic            valid;
  } if_id_t;

  // Masking (rather than slicing) keeps every address bit in use.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/if_fetch_unit_if_id_reg.sv
// IF/ID pipeline register.
//   clk, rst_n            : clock, async active-low reset
//   bubble, hold, load    : update controls, priority bubble > hold > load
//   load_instr, load_npc  : payload captured on load (valid forced to 1)
//   instr, npc, valid     : registered IF/ID contents
// With no control asserted the register takes a bubble.
module if_id_reg
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            bubble,
  input  logic            hold,
  input  logic            load,
  input  logic [XLEN-1:0] load_instr,
  input  logic [XLEN-1:0] load_npc,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] npc,
  output logic            valid
);

  localparam if_id_t BUBBLE = '{instr: NOP_INSTR, npc: XLEN'(0), valid: 1'b0};

  if_id_t q;

  // Register update in priority order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= BUBBLE;
    end else if (bubble) begin
      q <= BUBBLE;
    end else if (hold) begin
      q <= q;
    end else if (load) begin
      q <= '{instr: load_instr, npc: load_npc, valid: 1'b1};
    end else begin
      q <= BUBBLE;
    end
  end

  assign instr = q.instr;
  assign npc   = q.npc;
  assign valid = q.valid;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory
// request handshake, loads IF/ID and applies MEM-stage branch redirects.
//   clk, rst_n                       : clock, async active-low reset
//   PCSrc, branch_target             : taken-branch redirect from MEM
//   stall                            : hazard hold of PC and IF/ID
//   imem_req, imem_addr              : fetch request (registered)
//   imem_ready, imem_rdata           : memory accept / returned instruction
//   if_id_instr, if_id_npc, if_id_valid : IF/ID register
//   flush                            : downstream clear, follows PCSrc directly
//   pc                               : next fetch address (debug)
module if_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = DEF_RESET_PC,
  parameter logic [XLEN-1:0] NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            PCSrc,
  input  logic [XLEN-1:0] branch_target,
  input  logic            stall,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] if_id_instr,
  output logic [XLEN-1:0] if_id_npc,
  output logic            if_id_valid,
  output logic            flush,
  output logic [XLEN-1:0] pc
);

  fetch_state_e    state_q, state_nx;
  logic            boot_q;
  logic [XLEN-1:0] pc_q, pc_nx;
  logic [XLEN-1:0] drop_addr_q, drop_addr_nx;
  logic [XLEN-1:0] hbuf_instr_q, hbuf_instr_nx;
  logic [XLEN-1:0] hbuf_npc_q, hbuf_npc_nx;
  logic            imem_req_q, imem_req_nx;
  logic [XLEN-1:0] imem_addr_q, imem_addr_nx;
  logic [XLEN-1:0] pc_inc, tgt;
  logic            ifid_load;
  logic [XLEN-1:0] ifid_instr_d, ifid_npc_d;

  assign pc_inc = pc_q + PC_INC;
  assign tgt    = align_word(branch_target);

  // State, PC, drop address, hold buffer and request outputs.
  // boot_q gives one settling edge in IDLE after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      boot_q       <= 1'b0;
      pc_q         <= RESET_PC;
      drop_addr_q  <= XLEN'(0);
      hbuf_instr_q <= XLEN'(0);
      hbuf_npc_q   <= XLEN'(0);
      imem_req_q   <= 1'b0;
      imem_addr_q  <= RESET_PC;
    end else begin
      state_q      <= state_nx;
      boot_q       <= 1'b1;
      pc_q         <= pc_nx;
      drop_addr_q  <= drop_addr_nx;
      hbuf_instr_q <= hbuf_instr_nx;
      hbuf_npc_q   <= hbuf_npc_nx;
      imem_req_q   <= imem_req_nx;
      imem_addr_q  <= imem_addr_nx;
    end
  end

  // Next-state, PC and IF/ID load decisions.
  always_comb begin
    state_nx      = state_q;
    pc_nx         = pc_q;
    drop_addr_nx  = drop_addr_q;
    hbuf_instr_nx = hbuf_instr_q;
    hbuf_npc_nx   = hbuf_npc_q;
    ifid_load     = 1'b0;
    ifid_instr_d  = imem_rdata;
    ifid_npc_d    = pc_inc;

    case (state_q)
      IDLE: begin
        if (boot_q) state_nx = REQ;
        if (PCSrc)  pc_nx    = tgt;
      end
      REQ: begin
        if (imem_ready) begin
          if (PCSrc) begin
            pc_nx = tgt;
          end else if (stall) begin
            hbuf_instr_nx = imem_rdata;
            hbuf_npc_nx   = pc_inc;
            pc_nx         = pc_inc;
            state_nx      = HOLD;
          end else begin
            ifid_load = 1'b1;
            pc_nx     = pc_inc;
          end
        end else if (PCSrc) begin
          // Request cannot be withdrawn: keep presenting the old address.
          drop_addr_nx = pc_q;
          pc_nx        = tgt;
          state_nx     = DROP;
        end
      end
      HOLD: begin
        if (PCSrc) begin
          pc_nx    = tgt;
          state_nx = REQ;
        end else if (!stall) begin
          ifid_load    = 1'b1;
          ifid_instr_d = hbuf_instr_q;
          ifid_npc_d   = hbuf_npc_q;
          state_nx     = REQ;
        end
      end
      DROP: begin
        if (PCSrc)      pc_nx    = tgt;
        if (imem_ready) state_nx = REQ;
      end
      default: state_nx = IDLE;
    endcase

    imem_req_nx  = (state_nx == REQ) || (state_nx == DROP);
    imem_addr_nx = (state_nx == DROP) ? drop_addr_nx : pc_nx;
  end

  // PCSrc bubbles IF/ID even over a stall: the older branch wins.
  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .bubble     (PCSrc),
    .hold       (stall),
    .load       (ifid_load),
    .load_instr (ifid_instr_d),
    .load_npc   (ifid_npc_d),
    .instr      (if_id_instr),
    .npc        (if_id_npc),
    .valid      (if_id_valid)
  );

  assign imem_req  = imem_req_q;
  assign imem_addr = imem_addr_q;
  assign pc        = pc_q;
  assign flush     = PCSrc;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with an IF/ID scoreboard queue.
module tb_if_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] OFS = 32'h1000_0000;
  localparam if_id_t      BUB = '{instr: NOP, npc: 32'h0, valid: 1'b0};

  logic        clk = 1'b0;
  logic        rst_n, PCSrc, stall, imem_ready;
  logic        imem_req, flush, if_id_valid;
  logic [31:0] branch_target, imem_addr, imem_rdata;
  logic [31:0] if_id_instr, if_id_npc, pc;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  if_id_t sb[$];

  always #5 clk = ~clk;

  if_fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (NOP)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .PCSrc         (PCSrc),
    .branch_target (branch_target),
    .stall         (stall),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .if_id_instr   (if_id_instr),
    .if_id_npc     (if_id_npc),
    .if_id_valid   (if_id_valid),
    .flush         (flush),
    .pc            (pc)
  );

  function automatic if_id_t ent(input logic [31:0] i, input logic [31:0] n);
    return '{instr: i, npc: n, valid: 1'b1};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, memory returns addr+OFS, then score IF/ID.
  task automatic cyc(input logic rdy, input logic psrc, input logic [31:0] tgt,
                     input logic stl, input if_id_t exp);
    if_id_t e;
    imem_ready    = rdy;
    imem_rdata    = imem_addr + OFS;
    PCSrc         = psrc;
    branch_target = tgt;
    stall         = stl;
    sb.push_back(exp);
    #1 chk("flush", 32'(flush), 32'(psrc));
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("if_id_instr", if_id_instr, e.instr);
    chk("if_id_npc",   if_id_npc,   e.npc);
    chk("if_id_valid", 32'(if_id_valid), 32'(e.valid));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"},   32'(imem_req), 32'd0);
    chk({tag, "_addr"},  imem_addr, 32'h0);
    chk({tag, "_instr"}, if_id_instr, NOP);
    chk({tag, "_npc"},   if_id_npc, 32'h0);
    chk({tag, "_valid"}, 32'(if_id_valid), 32'd0);
    chk({tag, "_pc"},    pc, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0; PCSrc = 1'b0; stall = 1'b0; imem_ready = 1'b0;
    imem_rdata = 32'h0; branch_target = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    // Startup: IDLE after first edge, REQ at RESET_PC after second.
    cyc(1'b0, 1'b0, 32'h0, 1'b0, BUB);
    chk("boot_idle_req", 32'(imem_req), 32'd0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, BUB);
    chk("boot_req", 32'(imem_req), 32'd1);
    chk("boot_addr", imem_addr, 32'h0);

    // Zero-wait streaming.
    cyc(1'b1, 1'b0, 32'h0, 1'b0, ent(OFS + 32'h0, 32'h4));
    chk("seq_addr4", imem_addr, 32'h4);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, ent(OFS + 32'h4, 32'h8));
    chk("seq_addr8", imem_addr, 32'h8);

    // Stall on the cycle addr 8 returns, held two cycles.
    cyc(1'b1, 1'b0, 32'h0, 1'b1, ent(OFS + 32'h4, 32'h8));
    chk("hold_req0", 32'(imem_req), 32'd0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, ent(OFS + 32'h4, 32'h8));
    chk("hold_req1", 32'(imem_req), 32'd0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, ent(OFS + 32'h8, 32'hC));
    chk("hold_exit_req", 32'(imem_req), 32'd1);
    chk("hold_exit_addr", imem_addr, 32'hC);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, ent(OFS + 32'hC, 32'h10));
    chk("seq_addr16", imem_addr, 32'h10);

    // Taken branch with ready in REQ.
    cyc(1'b1, 1'b1, 32'h40, 1'b0, BUB);
    chk("br_addr", imem_addr, 32'h40);
    chk("br_pc", pc, 32'h40);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, ent(OFS + 32'h40, 32'h44));
    chk("br_next_addr", imem_addr, 32'h44);

    // Branch while a slow request is outstanding: DROP until ready.
    cyc(1'b0, 1'b1, 32'h80, 1'b0, BUB);
    chk("drop_req", 32'(imem_req), 32'd1);
    chk("drop_addr_w1", imem_addr, 32'h44);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, BUB);
    chk("drop_addr_w2", imem_addr, 32'h44);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, BUB);
    chk("drop_done_addr", imem_addr, 32'h80);
    chk("drop_done_req", 32'(imem_req), 32'd1);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, ent(OFS + 32'h80, 32'h84));
    chk("after_drop_addr", imem_addr, 32'h84);

    // Unaligned target is word-aligned.
    cyc(1'b1, 1'b1, 32'h43, 1'b0, BUB);
    chk("align_addr", imem_addr, 32'h40);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, ent(OFS + 32'h40, 32'h44));

    // PC wrap at the top of the address space.
    cyc(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, BUB);
    chk("wrap_top_addr", imem_addr, 32'hFFFF_FFFC);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, ent(32'h0FFF_FFFC, 32'h0));
    chk("wrap_addr", imem_addr, 32'h0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, ent(OFS, 32'h4));
    chk("wrap_next_addr", imem_addr, 32'h4);

    // Reset asserted mid-DROP.
    cyc(1'b0, 1'b1, 32'h100, 1'b0, BUB);
    chk("pre_rst_addr", imem_addr, 32'h4);
    chk("pre_rst_pc", pc, 32'h100);
    PCSrc = 1'b0; imem_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(1'b0, 1'b0, 32'h0, 1'b0, BUB);
    chk("rst2_idle_req", 32'(imem_req), 32'd0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, BUB);
    chk("rst2_req", 32'(imem_req), 32'd1);
    chk("rst2_addr", imem_addr, 32'h0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, ent(OFS, 32'h4));
    chk("rst2_next_addr", imem_addr, 32'h4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage for the five-stage pipeline. It owns the PC and drives the instruction-memory request handshake. It loads the IF/ID pipeline register and consumes the MEM-stage branch decision: PCSrc (Branch & Zero) and the branch target. A taken branch redirects fetch, squashes wrong-path work, and discards any in-flight memory response.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset
- NOP_INSTR, 32'h0000_0000, bubble encoding written into IF/ID

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- PCSrc  in  1  taken branch resolved in MEM
- branch_target  in  32  redirect address, valid when PCSrc=1
- stall  in  1  hazard-unit hold of PC and IF/ID
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch address, word aligned
- imem_ready  in  1  memory accepts request and returns data this cycle
- imem_rdata  in  32  instruction, valid when imem_req & imem_ready
- if_id_instr  out  32  IF/ID instruction
- if_id_npc  out  32  IF/ID PC+4
- if_id_valid  out  1  IF/ID holds a real instruction
- flush  out  1  clear ID/EX and EX/MEM; combinationally equal to PCSrc
- pc  out  32  next fetch address, for debug

## Operation
- FSM states are IDLE, REQ, HOLD and DROP.
- IDLE
  - imem_req=0.
  - Goes to REQ the next cycle unconditionally.
- REQ
  - imem_req=1 and imem_addr=pc.
  - Request and address stay stable until imem_ready. A request is never withdrawn, even under stall.
  - On ready with PCSrc=1: discard rdata, pc<=branch_target, IF/ID<=bubble, stay in REQ.
  - On ready with stall=1: buffer rdata and pc+4 in the hold register, pc<=pc+4, go to HOLD.
  - On ready otherwise: IF/ID<={rdata, pc+4, valid=1}, pc<=pc+4, stay in REQ.
  - No ready, with PCSrc=1: drop_addr<=pc, pc<=branch_target, IF/ID<=bubble, go to DROP.
- HOLD
  - imem_req=0.
  - PCSrc=1: discard the buffer, pc<=branch_target, IF/ID<=bubble, go to REQ.
  - stall=0: IF/ID<=buffer with valid=1, go to REQ.
- DROP
  - imem_req=1 and imem_addr=drop_addr.
  - On ready: discard rdata, go to REQ (fetches the new pc).
  - A further PCSrc only updates pc and bubbles IF/ID.
- IF/ID update priority: PCSrc (bubble) > stall (hold) > new instruction > bubble.
  - A bubble is {NOP_INSTR, npc=0, valid=0}.
  - If no instruction is delivered and stall=0, IF/ID becomes a bubble.
- Address rules:
  - branch_target[1:0] is forced to 2'b00.
  - pc+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- A PCSrc arriving while IF/ID is stalled still bubbles IF/ID, because the older branch wins.

## Timing
- Reset values:
  - State IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC.
  - if_id_instr=NOP_INSTR, if_id_npc=0, if_id_valid=0.
  - Hold buffer and drop_addr empty.
- Reset is asynchronous and can assert mid-request. The outstanding response is abandoned, and memory shares rst_n.
- After rst_n deasserts: first edge gives IDLE, second edge gives REQ with imem_addr=RESET_PC.
- Zero-wait memory (ready=1 in the request cycle):
  - Instruction appears in IF/ID one cycle after its request cycle.
  - Throughput is one per cycle.
- Redirect: with PCSrc at edge k, imem_addr=branch_target in cycle k+1 if nothing is outstanding. Otherwise it follows the DROP completion.
- flush is combinational, so downstream clears happen at the same edge as the redirect.

## Structure
- Shared package fetch_pkg holds:
  - the state enum (IDLE, REQ, HOLD, DROP)
  - default NOP_INSTR and RESET_PC
  - the PC_INC=4 constant
  - the IF/ID payload struct {instr, npc, valid}
- Sub-module if_id_reg: IF/ID register with load, hold and bubble controls and async active-low reset.
- Top level contains the FSM, pc, drop_addr and the one-entry hold buffer.

## Test plan
- Reset release, always-ready memory returning addr+32'h1000_0000:
  - imem_addr sequence is 0, 4, 8.
  - if_id_valid rises two cycles after request start, with if_id_npc=4, 8, 12.
- PCSrc=1 with branch_target=32'h40 while in REQ and ready=1:
  - flush=1 that cycle.
  - Next cycle IF/ID is a bubble and imem_addr=32'h40.
- Memory with 3-cycle ready latency, PCSrc pulsed in the first wait cycle with target 32'h80:
  - imem_addr stays at the old address until ready.
  - That data is never loaded into IF/ID.
  - The next request is 32'h80.
- stall=1 asserted the cycle data returns at addr 8, held for 2 cycles:
  - imem_req=0 in HOLD.
  - IF/ID holds the prior instruction, then loads addr 8's word with npc=12 when stall drops.
- pc at 32'hFFFF_FFFC with ready=1:
  - next imem_addr=0 and if_id_npc=0.
  - Separately, branch_target=32'h43 yields imem_addr=32'h40.
- rst_n asserted mid-DROP:
  - All outputs return to reset values immediately.
  - Fetch restarts at RESET_PC.
